// File: rtl/uart_rx_sipo_param.sv
// Oversampled UART receive deserialiser with configurable frame format.
// A 2-flop synchroniser feeds a bit-timing FSM that takes a 3-sample majority
// near mid-bit. Completed frames land in a valid/ready output register with
// per-frame parity/frame/break flags and a one-cycle overrun pulse.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | line idle, waiting for rx_s = 0
// START    | timing the start bit; a majority of 1 is a false start
// DATA     | shifting payload bits in, LSB first
// PARITY   | checking the parity bit against the payload
// STOP     | sampling stop bit(s); the last one completes on its decision
// RECOVER  | last stop bit was 0; wait for the line to return high
module uart_rx_sipo_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 baud_clk,
    input  logic                 rst_n,
    input  logic                 data_tx,
    input  logic                 rx_ready,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_flag,
    output logic                 overrun,
    output logic                 active_flag
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] C_S0  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_S1  = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] C_DEC = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] C_END = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic          PAR_ODD = (PARITY_ODD != 0);

    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_params
        $error("uart_rx_sipo_param: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_RECOVER
    } state_t;

    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_s0;
    logic                 r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_perr_f;
    logic                 r_stop_err;
    logic                 r_stop_one;
    logic                 r_valid;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_brk;
    logic                 r_overrun;

    logic w_rx_s;
    logic w_maj;
    logic w_in_bit;
    logic w_dec;
    logic w_cnt_end;
    logic w_last_stop;
    logic w_stop_err;
    logic w_stop_one;
    logic w_brk;
    logic w_par_exp;

    assign w_rx_s      = r_sync2;
    assign w_maj       = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
    assign w_in_bit    = (r_state == S_START) || (r_state == S_DATA) ||
                         (r_state == S_PARITY) || (r_state == S_STOP);
    assign w_dec       = (r_cnt == C_DEC);
    assign w_cnt_end   = (r_cnt == C_END);
    assign w_last_stop = (STOP_BITS == 1) ? 1'b1 : r_stop_idx;
    // Accumulated stop-bit status including the bit being decided now.
    assign w_stop_err  = r_stop_err | ~w_maj;
    assign w_stop_one  = r_stop_one | w_maj;
    assign w_brk       = (r_shift == '0) && !r_par_bit && !w_stop_one;
    assign w_par_exp   = (^r_shift) ^ PAR_ODD;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= data_tx;
            r_sync2 <= r_sync1;
        end
    end

    // Frame FSM, bit timing, majority sampling and output register.
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_perr_f   <= 1'b0;
            r_stop_err <= 1'b0;
            r_stop_one <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_brk      <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;

            // Consumer takes the held word; a commit below overrides this.
            if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
                r_perr  <= 1'b0;
                r_ferr  <= 1'b0;
                r_brk   <= 1'b0;
            end

            if (w_in_bit) begin
                r_cnt <= w_cnt_end ? '0 : r_cnt + 1'b1;
                if (r_cnt == C_S0) r_s0 <= w_rx_s;
                if (r_cnt == C_S1) r_s1 <= w_rx_s;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_state    <= S_START;
                        r_cnt      <= '0;
                        r_bit_idx  <= '0;
                        r_stop_idx <= 1'b0;
                        r_par_bit  <= 1'b0;
                        r_perr_f   <= 1'b0;
                        r_stop_err <= 1'b0;
                        r_stop_one <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_dec && w_maj) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (w_cnt_end) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_dec) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                    if (w_cnt_end) begin
                        if (r_bit_idx == B_LAST) begin
                            r_bit_idx <= '0;
                            r_state   <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_dec) begin
                        r_par_bit <= w_maj;
                        r_perr_f  <= w_maj ^ w_par_exp;
                    end
                    if (w_cnt_end) r_state <= S_STOP;
                end
                S_STOP: begin
                    if (w_dec) begin
                        if (w_last_stop) begin
                            // Completing early on the decision cycle lets an
                            // immediately following start edge be caught.
                            r_state <= w_maj ? S_IDLE : S_RECOVER;
                            r_cnt   <= '0;
                            if (!r_valid || rx_ready) begin
                                r_valid <= 1'b1;
                                r_data  <= r_shift;
                                r_perr  <= r_perr_f;
                                r_ferr  <= w_stop_err;
                                r_brk   <= w_brk;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_stop_err <= w_stop_err;
                            r_stop_one <= w_stop_one;
                        end
                    end else if (w_cnt_end) begin
                        r_stop_idx <= 1'b1;
                    end
                end
                S_RECOVER: begin
                    if (w_rx_s) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_valid    = r_valid;
    assign rx_data     = r_data;
    assign parity_err  = r_perr;
    assign frame_err   = r_ferr;
    assign break_flag  = r_brk;
    assign overrun     = r_overrun;
    assign active_flag = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sipo_param.sv
// Bench for uart_rx_sipo_param: three instances (8N1, 8E1, 9O2, all OS=16)
// driven from frame tasks; expected words are queued at send time and
// compared when each instance hands a word over.
module tb_uart_rx_sipo_param;

    localparam int OS = 16;

    logic baud_clk = 1'b0;
    logic rst_n    = 1'b0;
    logic tx0 = 1'b1, tx1 = 1'b1, tx2 = 1'b1;
    logic rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;

    logic       vld0, vld1, vld2;
    logic [7:0] d0, d1;
    logic [8:0] d2;
    logic       pe0, pe1, pe2, fe0, fe1, fe2, bk0, bk1, bk2;
    logic       ov0, ov1, ov2, act0, act1, act2;

    always #5 baud_clk = ~baud_clk;

    uart_rx_sipo_param #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .OVERSAMPLE(OS)) u_dut0 (
        .baud_clk(baud_clk), .rst_n(rst_n), .data_tx(tx0), .rx_ready(rdy0),
        .rx_valid(vld0), .rx_data(d0), .parity_err(pe0), .frame_err(fe0),
        .break_flag(bk0), .overrun(ov0), .active_flag(act0));

    uart_rx_sipo_param #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .OVERSAMPLE(OS)) u_dut1 (
        .baud_clk(baud_clk), .rst_n(rst_n), .data_tx(tx1), .rx_ready(rdy1),
        .rx_valid(vld1), .rx_data(d1), .parity_err(pe1), .frame_err(fe1),
        .break_flag(bk1), .overrun(ov1), .active_flag(act1));

    uart_rx_sipo_param #(.DATA_BITS(9), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2), .OVERSAMPLE(OS)) u_dut2 (
        .baud_clk(baud_clk), .rst_n(rst_n), .data_tx(tx2), .rx_ready(rdy2),
        .rx_valid(vld2), .rx_data(d2), .parity_err(pe2), .frame_err(fe2),
        .break_flag(bk2), .overrun(ov2), .active_flag(act2));

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int deliv[3] = '{0, 0, 0};
    int ovc[3]   = '{0, 0, 0};
    int e0[3]    = '{0, 0, 0};
    int lat0     = -1;
    logic pv0    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge baud_clk) cyc <= cyc + 1;

    task automatic take(input int k, input logic [8:0] d, input logic p, input logic f, input logic b);
        exp_t e;
        int   sz;
        sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
            check($sformatf("dut%0d_unexpected_word_queue_depth", k), 32'(sz), 32'd1);
            return;
        end
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        check($sformatf("dut%0d_rx_data", k), 32'(d), 32'(e.d));
        check($sformatf("dut%0d_parity_err", k), 32'(p), 32'(e.pe));
        check($sformatf("dut%0d_frame_err", k), 32'(f), 32'(e.fe));
        check($sformatf("dut%0d_break_flag", k), 32'(b), 32'(e.bk));
        deliv[k]++;
    endtask

    // Monitor: a word is handed over wherever valid and ready meet.
    always @(negedge baud_clk) begin
        if (rst_n) begin
            if (ov0) ovc[0]++;
            if (ov1) ovc[1]++;
            if (ov2) ovc[2]++;
            if (vld0 && !pv0 && lat0 < 0) lat0 = cyc - e0[0];
            pv0 = vld0;
            if (vld0 && rdy0) take(0, {1'b0, d0}, pe0, fe0, bk0);
            if (vld1 && rdy1) take(1, {1'b0, d1}, pe1, fe1, bk1);
            if (vld2 && rdy2) take(2, d2, pe2, fe2, bk2);
        end else begin
            pv0 = 1'b0;
        end
    end

    task automatic tick();
        @(negedge baud_clk);
        #1;
    endtask

    task automatic wait_bit();
        repeat (OS) tick();
    endtask

    task automatic drive(input int k, input logic v);
        case (k)
            0:       tx0 = v;
            1:       tx1 = v;
            default: tx2 = v;
        endcase
    endtask

    function automatic logic good_par(input int k, input logic [8:0] d);
        return (^d) ^ (k == 2);
    endfunction

    task automatic push_exp(input int k, input logic [8:0] data, input logic par, input logic stopv);
        exp_t e;
        logic pen;
        pen  = (k != 0);
        e.d  = data;
        e.pe = pen && (par != good_par(k, data));
        e.fe = !stopv;
        e.bk = (data == 9'd0) && (!pen || !par) && !stopv;
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Drives one frame on line k; called just after a falling clock edge.
    task automatic send_bits(input int k, input logic [8:0] data, input logic par, input logic stopv);
        int nb;
        int ns;
        nb = (k == 2) ? 9 : 8;
        ns = (k == 2) ? 2 : 1;
        e0[k] = cyc + 1;
        drive(k, 1'b0);
        wait_bit();
        for (int i = 0; i < nb; i++) begin
            drive(k, data[i]);
            wait_bit();
        end
        if (k != 0) begin
            drive(k, par);
            wait_bit();
        end
        for (int i = 0; i < ns; i++) begin
            drive(k, stopv);
            wait_bit();
        end
        drive(k, 1'b1);
    endtask

    task automatic tx_frame(input int k, input logic [8:0] data, input logic par, input bit push);
        if (push) push_exp(k, data, par, 1'b1);
        send_bits(k, data, par, 1'b1);
    endtask

    task automatic wait_deliv(input string tag, input int k, input int target, input int max_cyc);
        for (int i = 0; i < max_cyc && deliv[k] < target; i++) tick();
        check(tag, 32'(deliv[k]), 32'(target));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int acnt;
        logic [8:0] part;

        // Reset state
        repeat (3) tick();
        check("rst_valid", 32'(vld0), 32'd0);
        check("rst_data", 32'(d2), 32'd0);
        check("rst_flags", {29'd0, pe1, fe1, bk1}, 32'd0);
        check("rst_overrun_active", {30'd0, ov0, act0}, 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();
        check("idle_after_reset", {29'd0, act0, act1, act2}, 32'd0);

        // 8N1 0xA5 with latency
        tx_frame(0, 9'h0A5, 1'b0, 1'b1);
        wait_deliv("t1_delivered", 0, 1, 50);
        check("t1_latency", 32'(lat0), 32'd156);
        tick();
        check("t1_valid_one_cycle", 32'(vld0), 32'd0);
        check("t1_no_overrun", 32'(ovc[0]), 32'd0);

        // 8E1 parity error then clean parity
        tx_frame(1, 9'h003, 1'b1, 1'b1);
        tx_frame(1, 9'h003, 1'b0, 1'b1);
        wait_deliv("t2_delivered", 1, 2, 50);

        // False start
        tick();
        acnt = 0;
        tx1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5) tx1 = 1'b1;
            tick();
            if (act1) acnt++;
        end
        check("t3_active_seen", 32'(acnt > 0), 32'd1);
        check("t3_active_bound", 32'(acnt <= OS / 2 + 4), 32'd1);
        check("t3_no_frame", 32'(deliv[1]), 32'd2);

        // Break: line low for 12 bit times
        push_exp(1, 9'h000, 1'b0, 1'b0);
        tx1 = 1'b0;
        for (int i = 0; i < 12 * OS; i++) tick();
        check("t4_recover_active", 32'(act1), 32'd1);
        check("t4_one_frame", 32'(deliv[1]), 32'd3);
        tx1 = 1'b1;
        repeat (4) tick();
        check("t4_idle_after_release", 32'(act1), 32'd0);
        repeat (3 * OS) tick();
        check("t4_still_one_frame", 32'(deliv[1]), 32'd3);

        // Overrun with consumer stalled
        rdy1 = 1'b0;
        tx_frame(1, 9'h011, good_par(1, 9'h011), 1'b1);
        tx_frame(1, 9'h022, good_par(1, 9'h022), 1'b0);
        repeat (5) tick();
        check("t5_valid_held", 32'(vld1), 32'd1);
        check("t5_data_held", 32'(d1), 32'h11);
        check("t5_overrun_one_pulse", 32'(ovc[1]), 32'd1);
        @(posedge baud_clk);
        #1;
        rdy1 = 1'b1;
        tick();
        check("t5_delivered", 32'(deliv[1]), 32'd4);
        tick();
        check("t5_valid_cleared", 32'(vld1), 32'd0);

        // 9O2, reset mid-frame, then recovery
        tx_frame(2, 9'h1FF, good_par(2, 9'h1FF), 1'b1);
        wait_deliv("t6_first_delivered", 2, 1, 50);
        repeat (4) tick();
        part = 9'h155;
        drive(2, 1'b0);
        wait_bit();
        for (int i = 0; i < 4; i++) begin
            drive(2, part[i]);
            wait_bit();
        end
        drive(2, part[4]);
        repeat (OS / 2) tick();
        check("t6_active_midframe", 32'(act2), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_data", 32'(d2), 32'd0);
        check("t6_rst_valid_flags", {28'd0, vld2, pe2, fe2, bk2}, 32'd0);
        check("t6_rst_overrun_active", {30'd0, ov2, act2}, 32'd0);
        drive(2, 1'b1);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        tx_frame(2, 9'h100, good_par(2, 9'h100), 1'b1);
        wait_deliv("t6_second_delivered", 2, 2, 50);

        repeat (4) tick();
        check("queues_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_sipo_param.md
Name: uart_rx_sipo_param

Overview:
- Parametrised successor to the fixed 11-bit receive shifter.
- Oversampled UART receive deserialiser with configurable data width, parity mode, stop-bit count and oversampling ratio.
- Uses 3-sample majority voting, false-start rejection, per-frame error flags, break detection, and a valid/ready output register with overrun reporting.
- Sits between the baud sampling unit (supplies baud_clk at OVERSAMPLE × bit rate) and the deframe/FIFO consumer.

Parameters:
- DATA_BITS, 8: payload bits per frame; legal range 5..9; sent LSB first.
- PARITY_EN, 1: 1 = one parity bit follows the data; 0 = no parity bit.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1: 1 or 2.
- OVERSAMPLE, 16: baud_clk cycles per bit; even, minimum 8.

Ports:
- baud_clk, input, 1: oversampling clock; the only clock.
- rst_n, input, 1: asynchronous active-low reset.
- data_tx, input, 1: serial line from the transmitter; asynchronous; idles high.
- rx_ready, input, 1: consumer accepts the held word.
- rx_valid, output, 1: rx_data and the error flags hold a completed frame.
- rx_data, output, DATA_BITS: received payload.
- parity_err, output, 1: parity mismatch for the held frame.
- frame_err, output, 1: at least one stop bit sampled 0 for the held frame.
- break_flag, output, 1: the held frame was all zeros including the stop bit(s).
- overrun, output, 1: one-cycle pulse; a completed frame was dropped.
- active_flag, output, 1: high while the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - FSM goes to IDLE; counters go to 0.
  - Both synchroniser flops go to 1.
  - rx_valid=0, rx_data=0, parity_err=0, frame_err=0, break_flag=0, overrun=0, active_flag=0.
- Input path: data_tx passes through a 2-flop synchroniser to give rx_s. All decisions use rx_s.
- Bit timing:
  - Counter cnt runs 0..OS-1 in every bit state (OS = OVERSAMPLE) and increments each cycle.
  - rx_s is sampled at cnt = OS/2-1, OS/2 and OS/2+1.
  - The bit value is the 2-of-3 majority, decided on the cnt = OS/2+1 cycle.
  - The bit ends on cnt = OS-1; the next state is entered with cnt=0.
- FSM states: IDLE, START, DATA, PARITY, STOP, RECOVER.
  - IDLE: when rx_s=0, go to START with cnt=0.
  - START: if the majority is 1, go to IDLE (false start; no outputs change). Otherwise go to DATA at the bit end.
  - DATA: shift the majority bit into bit position bit_idx (LSB first). After DATA_BITS bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: compare the majority with the XOR of the data, XORed with PARITY_ODD. A mismatch sets the frame's parity error.
  - STOP: the first stop bit (when STOP_BITS=2) runs a full bit period. The last stop bit completes on its decision cycle (no wait to cnt=OS-1), which allows resync to the next start edge.
- Frame completion (decision cycle of the last stop bit):
  - Any stop majority of 0 gives frame error.
  - Break = all data bits 0, parity bit (if present) 0, and every stop bit 0. Break implies frame_err=1.
  - Next state: RECOVER if the last stop bit was 0, else IDLE.
  - RECOVER: wait for rx_s=1, then go to IDLE. A held-low line never produces a second frame.
- Output register commit (at frame completion):
  - If rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle: load rx_data and the three flags; rx_valid=1 from the next cycle.
  - If rx_valid=1 with rx_ready=0: the new frame is dropped, the held word and flags are unchanged, and overrun=1 for exactly one cycle.
- Handshake:
  - rx_valid=1 with rx_ready=1 and no simultaneous commit: rx_valid=0 next cycle and the flags clear to 0.
  - rx_data is held stable while rx_valid=1.
- Latency:
  - E0 = first baud_clk edge sampling data_tx=0.
  - N = 1 + DATA_BITS + PARITY_EN + STOP_BITS − 1.
  - rx_valid is first high after edge E(N·OS + OS/2 + 4).
  - For 8 data bits, no parity, 1 stop (8N1), OS=16: after E156.
- Arithmetic: cnt is $clog2(OS) bits wide and bit_idx is $clog2(DATA_BITS+1) bits wide. Neither wraps except by the explicit reset to 0 at bit end.

Test Plan:
1. 8N1, PARITY_EN=0, OS=16; send 0xA5 with rx_ready=1 → rx_valid high after E156 for one cycle, rx_data=0xA5, parity_err=0, frame_err=0, break_flag=0, overrun=0.
2. 8E1; send 0x03 with the parity bit forced to 1 → rx_data=0x03, parity_err=1, frame_err=0. Then resend with parity bit 0 → parity_err=0.
3. data_tx low for 5 cycles, then high → active_flag high then back to 0 within OS/2+4 cycles after entering START; rx_valid never asserts.
4. Line held low for 12 bit times, then released → rx_valid with rx_data=0, frame_err=1, break_flag=1. FSM stays in RECOVER (active_flag=1) until rx_s=1, then IDLE. Exactly one frame is delivered.
5. rx_ready=0; send 0x11 then 0x22 → rx_valid held with 0x11; overrun pulses one cycle at the second frame's completion. Raising rx_ready then delivers 0x11, and rx_valid=0 the next cycle.
6. 9 data bits, 2 stop bits, odd parity; send 0x1FF and assert rst_n=0 at mid-data of the next frame → all outputs are 0 immediately. After release, the next frame 0x100 is received correctly.
